// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the multi-mode sequence generator.
//   seq_mode_e           : sequence selector (Padovan, Fibonacci, arithmetic, Galois LFSR)
//   DEFAULT_LFSR_TAPS_32 : maximal-length Galois feedback mask for 32-bit state
package seq_gen_pkg;

    typedef enum logic [1:0] {
        SEQ_PADOVAN = 2'd0,
        SEQ_FIB     = 2'd1,
        SEQ_ARITH   = 2'd2,
        SEQ_LFSR    = 2'd3
    } seq_mode_e;

    localparam logic [31:0] DEFAULT_LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/seq_gen_next.sv
// Combinational successor function for the sequence generator state.
//   mode   : active sequence (registered copy held by the top)
//   a/b/c  : current state registers, a is the visible term
//   step_i : live increment used by the arithmetic progression
//   a_n/b_n/c_n : state after one advance
//   carry  : the advance's sum overflowed WIDTH bits (never set for LFSR)
module seq_gen_next
    import seq_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_LFSR_TAPS_32)
) (
    input  seq_mode_e        mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] step_i,
    output logic [WIDTH-1:0] a_n,
    output logic [WIDTH-1:0] b_n,
    output logic [WIDTH-1:0] c_n,
    output logic             carry
);

    // One extra bit so the carry out of the top bit is visible.
    logic [WIDTH:0] sum;

    always_comb begin
        a_n   = a;
        b_n   = b;
        c_n   = c;
        carry = 1'b0;
        sum   = '0;
        unique case (mode)
            SEQ_PADOVAN: begin
                sum   = {1'b0, a} + {1'b0, b};
                a_n   = b;
                b_n   = c;
                c_n   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            SEQ_FIB: begin
                sum   = {1'b0, a} + {1'b0, b};
                a_n   = b;
                b_n   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            SEQ_ARITH: begin
                sum   = {1'b0, a} + {1'b0, step_i};
                a_n   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            SEQ_LFSR: begin
                a_n = (a >> 1) ^ (a[0] ? LFSR_TAPS : '0);
            end
        endcase
    end

endmodule

// File: rtl/seq_generator_multi.sv
// Multi-mode integer sequence generator with a valid/ready output stream.
//   clk_w   : clock, rising edge
//   reset_w : synchronous active-low reset
//   mode_i  : sequence select, latched on reset or load_i
//   seed_i  : start value for ARITH/LFSR, latched on reset or load_i
//   step_i  : ARITH increment, used live on each advance
//   load_i  : restart with mode_i/seed_i, keeps the stream valid
//   ready_i : downstream accepts the current term
//   seq_o_w : current term (registered)
//   valid_o : seq_o_w holds a term; low only after a reset edge
//   wrap_o  : one-cycle pulse, the last advance overflowed
//   count_o : accepted terms since reset/load, wraps
module seq_generator_multi
    import seq_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      COUNT_W   = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_LFSR_TAPS_32)
) (
    input  logic               clk_w,
    input  logic               reset_w,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH-1:0]   seed_i,
    input  logic [WIDTH-1:0]   step_i,
    input  logic               load_i,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   seq_o_w,
    output logic               valid_o,
    output logic               wrap_o,
    output logic [COUNT_W-1:0] count_o
);

    seq_mode_e          mode_q;
    logic [WIDTH-1:0]   a_q, b_q, c_q;
    logic               valid_q, wrap_q;
    logic [COUNT_W-1:0] count_q;

    logic [WIDTH-1:0]   a_n, b_n, c_n;
    logic               carry;
    logic [WIDTH-1:0]   init_a, init_b, init_c;

    seq_gen_next #(
        .WIDTH     (WIDTH),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_next (
        .mode   (mode_q),
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .step_i (step_i),
        .a_n    (a_n),
        .b_n    (b_n),
        .c_n    (c_n),
        .carry  (carry)
    );

    // Initial state for whatever mode is being latched this cycle.
    always_comb begin
        init_a = '0;
        init_b = '0;
        init_c = '0;
        unique case (seq_mode_e'(mode_i))
            SEQ_PADOVAN: begin
                init_b = WIDTH'(1);
                init_c = WIDTH'(1);
            end
            SEQ_FIB: begin
                init_b = WIDTH'(1);
            end
            SEQ_ARITH: begin
                init_a = seed_i;
            end
            SEQ_LFSR: begin
                // An all-zero LFSR never leaves zero.
                init_a = (seed_i == '0) ? WIDTH'(1) : seed_i;
            end
        endcase
    end

    always_ff @(posedge clk_w) begin
        if (!reset_w || load_i) begin
            mode_q  <= seq_mode_e'(mode_i);
            a_q     <= init_a;
            b_q     <= init_b;
            c_q     <= init_c;
            wrap_q  <= 1'b0;
            count_q <= '0;
            // Reset drops valid; a load keeps the stream running.
            valid_q <= reset_w;
        end else if (valid_q && ready_i) begin
            a_q     <= a_n;
            b_q     <= b_n;
            c_q     <= c_n;
            wrap_q  <= carry;
            count_q <= count_q + COUNT_W'(1);
            valid_q <= 1'b1;
        end else begin
            wrap_q  <= 1'b0;
            valid_q <= 1'b1;
        end
    end

    assign seq_o_w = a_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_seq_generator_multi.sv
// Self-checking bench for seq_generator_multi at WIDTH=8 with an 8-bit maximal LFSR.
module tb_seq_generator_multi;
    import seq_gen_pkg::*;

    localparam int unsigned     W    = 8;
    localparam int unsigned     CW   = 8;
    localparam logic [W-1:0]    TAPS = 8'hB8;

    logic          clk_w = 1'b0;
    logic          reset_w;
    logic [1:0]    mode_i;
    logic [W-1:0]  seed_i;
    logic [W-1:0]  step_i;
    logic          load_i;
    logic          ready_i;
    logic [W-1:0]  seq_o_w;
    logic          valid_o;
    logic          wrap_o;
    logic [CW-1:0] count_o;

    seq_generator_multi #(
        .WIDTH     (W),
        .COUNT_W   (CW),
        .LFSR_TAPS (TAPS)
    ) dut (
        .clk_w   (clk_w),
        .reset_w (reset_w),
        .mode_i  (mode_i),
        .seed_i  (seed_i),
        .step_i  (step_i),
        .load_i  (load_i),
        .ready_i (ready_i),
        .seq_o_w (seq_o_w),
        .valid_o (valid_o),
        .wrap_o  (wrap_o),
        .count_o (count_o)
    );

    always #5 clk_w = ~clk_w;

    typedef struct packed {
        logic [W-1:0]  seq;
        logic          valid;
        logic          wrap;
        logic [CW-1:0] count;
    } exp_t;

    exp_t sb_q[$];

    // Golden model state
    logic [W-1:0]  m_a, m_b, m_c;
    logic [1:0]    m_mode;
    logic          m_valid, m_wrap;
    logic [CW-1:0] m_count;
    int            hs;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pad_tbl [16] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4,
                                 8'd5, 8'd7, 8'd9, 8'd12, 8'd16, 8'd21, 8'd28, 8'd37};
    logic [7:0] fib_tbl [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] init_term(input logic [1:0] md, input logic [W-1:0] sd);
        if (md == 2'd2) return sd;
        if (md == 2'd3) return (sd == '0) ? W'(1) : sd;
        return '0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [W:0] s;
        if (!reset_w || load_i) begin
            m_mode = mode_i;
            m_a    = init_term(mode_i, seed_i);
            m_b    = (mode_i <= 2'd1) ? W'(1) : '0;
            m_c    = (mode_i == 2'd0) ? W'(1) : '0;
            m_wrap  = 1'b0;
            m_count = '0;
            m_valid = reset_w;
        end else if (m_valid && ready_i) begin
            hs++;
            m_wrap = 1'b0;
            case (m_mode)
                2'd0: begin
                    s = {1'b0, m_a} + {1'b0, m_b};
                    m_a = m_b; m_b = m_c; m_c = s[W-1:0]; m_wrap = s[W];
                end
                2'd1: begin
                    s = {1'b0, m_a} + {1'b0, m_b};
                    m_a = m_b; m_b = s[W-1:0]; m_wrap = s[W];
                end
                2'd2: begin
                    s = {1'b0, m_a} + {1'b0, step_i};
                    m_a = s[W-1:0]; m_wrap = s[W];
                end
                default: m_a = {1'b0, m_a[W-1:1]} ^ (m_a[0] ? TAPS : '0);
            endcase
            m_count = m_count + CW'(1);
            m_valid = 1'b1;
        end else begin
            m_wrap  = 1'b0;
            m_valid = 1'b1;
        end
    endtask

    // Push the expected result, clock, then pop and compare.
    task automatic tick();
        exp_t e;
        exp_t g;
        model_edge();
        e.seq = m_a; e.valid = m_valid; e.wrap = m_wrap; e.count = m_count;
        sb_q.push_back(e);
        @(posedge clk_w);
        #1;
        g = sb_q.pop_front();
        check("seq",   32'(seq_o_w), 32'(g.seq));
        check("valid", 32'(valid_o), 32'(g.valid));
        check("wrap",  32'(wrap_o),  32'(g.wrap));
        check("count", 32'(count_o), 32'(g.count));
    endtask

    initial begin
        int first_ret;
        int gap;
        logic [W-1:0] exp_init;

        m_a = '0; m_b = '0; m_c = '0; m_mode = '0;
        m_valid = 1'b0; m_wrap = 1'b0; m_count = '0; hs = 0;
        reset_w = 1'b0; mode_i = 2'd0; seed_i = '0; step_i = '0;
        load_i = 1'b0; ready_i = 1'b0;

        // Reset state, Padovan
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        reset_w = 1'b1;
        ready_i = 1'b1;
        tick();
        check("first_valid", 32'(valid_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("pad_term", 32'(seq_o_w), 32'(pad_tbl[i]));
            tick();
        end
        check("pad_count16", 32'(count_o), 32'd16);

        // Fibonacci with 8-bit overflow
        mode_i = 2'd1; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("fib_term", 32'(seq_o_w), 32'(fib_tbl[i]));
            check("fib_wrap", 32'(wrap_o), (i == 13) ? 32'd1 : 32'd0);
            if (i < 13) tick();
        end
        tick();
        check("fib_121", 32'(seq_o_w), 32'd121);
        ready_i = 1'b0;
        tick();
        check("stall_wrap", 32'(wrap_o), 32'd0);
        check("stall_hold", 32'(seq_o_w), 32'd121);

        // Arithmetic, load coincident with ready
        mode_i = 2'd2; seed_i = 8'd250; step_i = 8'd10; load_i = 1'b1; ready_i = 1'b1;
        tick();
        check("ar_seed", 32'(seq_o_w), 32'd250);
        check("ar_cnt0", 32'(count_o), 32'd0);
        load_i = 1'b0;
        tick();
        check("ar_4", 32'(seq_o_w), 32'd4);
        check("ar_wrap", 32'(wrap_o), 32'd1);
        tick();
        check("ar_14", 32'(seq_o_w), 32'd14);
        check("ar_wrap_clr", 32'(wrap_o), 32'd0);
        tick();
        check("ar_24", 32'(seq_o_w), 32'd24);

        // LFSR zero seed guard and period
        mode_i = 2'd3; seed_i = '0; load_i = 1'b1;
        tick();
        check("lfsr_guard", 32'(seq_o_w), 32'd1);
        load_i = 1'b0;
        mode_i = 2'd0; seed_i = 8'h55;  // ignored without load
        first_ret = 0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            check("lfsr_nz", 32'(seq_o_w != '0), 32'd1);
            if (seq_o_w == 8'd1 && first_ret == 0) first_ret = i;
        end
        check("lfsr_period", 32'(first_ret), 32'd255);
        check("cnt_255", 32'(count_o), 32'd255);
        tick();
        check("cnt_wrap0", 32'(count_o), 32'd0);

        // Random backpressure on an arithmetic stream with live step
        mode_i = 2'd2; seed_i = 8'd7; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        hs = 0;
        for (int i = 0; i < 200; i++) begin
            ready_i = 1'($urandom_range(0, 1));
            step_i  = W'($urandom);
            tick();
        end
        check("hs_count", 32'(count_o), 32'(hs % 256));

        // Random reset pulses and loads
        for (int k = 0; k < 20; k++) begin
            gap = int'($urandom_range(3, 3000));
            for (int j = 0; j < gap; j++) begin
                ready_i = 1'($urandom_range(0, 1));
                load_i  = ($urandom_range(0, 15) == 0);
                if (load_i) ready_i = 1'b1;
                mode_i  = 2'($urandom);
                seed_i  = W'($urandom);
                step_i  = W'($urandom);
                exp_init = init_term(mode_i, seed_i);
                tick();
                if (load_i) begin
                    check("load_term", 32'(seq_o_w), 32'(exp_init));
                    check("load_cnt",  32'(count_o), 32'd0);
                end
            end
            load_i  = 1'b0;
            reset_w = 1'b0;
            ready_i = 1'($urandom_range(0, 1));
            mode_i  = 2'($urandom);
            seed_i  = W'($urandom);
            exp_init = init_term(mode_i, seed_i);
            tick();
            check("rst_term",   32'(seq_o_w), 32'(exp_init));
            check("rst_cnt",    32'(count_o), 32'd0);
            check("rst_valid0", 32'(valid_o), 32'd0);
            reset_w = 1'b1;
        end
        tick();
        check("final_valid", 32'(valid_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
